// File: rtl/vec_issue_queue_if.sv
// Instruction stream link: one vector instruction plus its scalar operand, valid/ready handshake.
// The master drives vld/instr/xreg and the slave answers with rdy.
interface vec_issue_queue_if;
    logic        vld;
    logic        rdy;
    logic [31:0] instr;
    logic [31:0] xreg;

    modport master (output vld, output instr, output xreg, input rdy);
    modport slave  (input vld, input instr, input xreg, output rdy);
endinterface

// File: rtl/vec_issue_queue.sv
// In-order issue buffer from scalar core to vector coprocessor; enq->deq latency 1 cycle, no bypass.
// Backpressure: enq.rdy = ~full; deq.vld drops when empty or when the in-flight cap is reached.
module vec_issue_queue #(
    parameter int DEPTH        = 4,
    parameter int MAX_INFLIGHT = 7,
    parameter int CNT_W        = $clog2(DEPTH) + 1
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_flush,
    input  logic               i_retire,
    vec_issue_queue_if.slave   enq,
    vec_issue_queue_if.master  deq,
    output logic               o_core_stall,
    output logic [CNT_W-1:0]   o_count,
    output logic               o_full,
    output logic               o_empty,
    output logic               o_idle,
    output logic               o_err
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int INF_W = $clog2(MAX_INFLIGHT + 1);

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] xreg;
    } entry_t;

    entry_t           r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic [INF_W-1:0] r_inflight;
    logic             r_err;

    logic w_full;
    logic w_empty;
    logic w_cap_ok;
    logic w_deq_vld;
    logic w_enq_take;
    logic w_deq_take;

    assign w_full    = (r_count == CNT_W'(DEPTH));
    assign w_empty   = (r_count == '0);
    assign w_cap_ok  = (r_inflight < INF_W'(MAX_INFLIGHT));
    assign w_deq_vld = ~w_empty & w_cap_ok;

    // A flush swallows any handshake seen on either side in the same cycle.
    assign w_enq_take = enq.vld & ~w_full & ~i_flush;
    assign w_deq_take = w_deq_vld & deq.rdy & ~i_flush;

    assign enq.rdy   = ~w_full;
    assign deq.vld   = w_deq_vld;
    assign deq.instr = r_mem[r_rd_ptr].instr;
    assign deq.xreg  = r_mem[r_rd_ptr].xreg;

    assign o_core_stall = enq.vld & w_full;
    assign o_count      = r_count;
    assign o_full       = w_full;
    assign o_empty      = w_empty;
    assign o_idle       = w_empty & (r_inflight == '0);
    assign o_err        = r_err;

    always_ff @(posedge i_clk) begin
        if (w_enq_take && !i_rst) begin
            r_mem[r_wr_ptr] <= '{instr: enq.instr, xreg: enq.xreg};
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_enq_take) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_deq_take) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_enq_take, w_deq_take})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // In-flight ops survive a flush: they already left the queue.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_inflight <= '0;
            r_err      <= 1'b0;
        end else if (w_deq_take && !i_retire) begin
            r_inflight <= r_inflight + INF_W'(1);
        end else if (!w_deq_take && i_retire) begin
            if (r_inflight == '0) begin
                r_err <= 1'b1;
            end else begin
                r_inflight <= r_inflight - INF_W'(1);
            end
        end
    end
endmodule

// File: tb/tb_vec_issue_queue.sv
// Directed bench for vec_issue_queue with a queue-based reference model checked every cycle.
module tb_vec_issue_queue;
    localparam int DEPTH   = 4;
    localparam int MAX_INF = 7;
    localparam int CNT_W   = 3;

    logic             clk = 1'b0;
    logic             rst;
    logic             flush;
    logic             retire;
    logic             core_stall;
    logic [CNT_W-1:0] count;
    logic             full;
    logic             empty;
    logic             idle;
    logic             err;

    vec_issue_queue_if enq_if ();
    vec_issue_queue_if deq_if ();

    vec_issue_queue #(.DEPTH(DEPTH), .MAX_INFLIGHT(MAX_INF), .CNT_W(CNT_W)) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_flush      (flush),
        .i_retire     (retire),
        .enq          (enq_if),
        .deq          (deq_if),
        .o_core_stall (core_stall),
        .o_count      (count),
        .o_full       (full),
        .o_empty      (empty),
        .o_idle       (idle),
        .o_err        (err)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model: queue of {instr,xreg}, in-flight counter, sticky error.
    logic [63:0] m_q [$];
    int          m_inf  = 0;
    bit          m_err  = 1'b0;
    bit          chk_en = 1'b0;
    bit          m_ef;
    bit          m_df;
    int          m_n;
    bit          m_dv;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        if (rst) begin
            m_q.delete();
            m_inf  = 0;
            m_err  = 1'b0;
            chk_en = 1'b1;
        end else if (chk_en) begin
            m_ef = enq_if.vld && (m_q.size() < DEPTH) && !flush;
            m_df = deq_if.rdy && (m_q.size() > 0) && (m_inf < MAX_INF) && !flush;
            if (flush) begin
                m_q.delete();
            end else begin
                if (m_df) void'(m_q.pop_front());
                if (m_ef) m_q.push_back({enq_if.instr, enq_if.xreg});
            end
            if (m_df && !retire) begin
                m_inf++;
            end else if (!m_df && retire) begin
                if (m_inf == 0) m_err = 1'b1;
                else m_inf--;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            m_n  = m_q.size();
            m_dv = (m_n != 0) && (m_inf < MAX_INF);
            chk("count", count, m_n);
            chk("full", full, m_n == DEPTH);
            chk("empty", empty, m_n == 0);
            chk("idle", idle, (m_n == 0) && (m_inf == 0));
            chk("err", err, m_err);
            chk("enq_rdy", enq_if.rdy, m_n != DEPTH);
            chk("deq_vld", deq_if.vld, m_dv);
            chk("core_stall", core_stall, enq_if.vld && (m_n == DEPTH));
            if (m_dv) chk("deq_dat", {deq_if.instr, deq_if.xreg}, m_q[0]);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst        = 1'b1;
        flush      = 1'b0;
        retire     = 1'b0;
        enq_if.vld = 1'b0;
        deq_if.rdy = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    task automatic drive_enq(input bit v, input logic [31:0] instr, input logic [31:0] xreg);
        enq_if.vld   = v;
        enq_if.instr = instr;
        enq_if.xreg  = xreg;
    endtask

    initial begin
        int  sent;
        int  cyc;
        bit  acc;

        rst = 1'b1; flush = 1'b0; retire = 1'b0;
        drive_enq(1'b0, 32'h0, 32'h0);
        deq_if.rdy = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("rst_empty", empty, 1);
        chk("rst_enq_rdy", enq_if.rdy, 1);
        chk("rst_deq_vld", deq_if.vld, 0);
        chk("rst_idle", idle, 1);
        chk("rst_full", full, 0);
        chk("rst_stall", core_stall, 0);
        tick();

        // 1: single entry round trip
        drive_enq(1'b1, 32'h0000_0057, 32'h11);
        deq_if.rdy = 1'b1;
        tick();
        enq_if.vld = 1'b0;
        @(negedge clk);
        chk("t1_deq_vld", deq_if.vld, 1);
        chk("t1_instr", deq_if.instr, 32'h57);
        chk("t1_xreg", deq_if.xreg, 32'h11);
        tick();
        @(negedge clk);
        chk("t1_empty", empty, 1);
        tick();
        retire = 1'b1;
        tick();
        retire = 1'b0;

        // 2: fill to full, fifth rejected, enq+deq at full
        do_reset();
        for (int i = 0; i < 5; i++) begin
            drive_enq(1'b1, 32'h100 + i, i);
            if (i == 4) begin
                @(negedge clk);
                chk("t2_stall", core_stall, 1);
                chk("t2_count4", count, 4);
                chk("t2_full", full, 1);
            end
            tick();
        end
        drive_enq(1'b1, 32'h200, 32'h20);
        deq_if.rdy = 1'b1;
        @(negedge clk);
        chk("t2_full_rdy", enq_if.rdy, 0);
        tick();
        enq_if.vld = 1'b0;
        deq_if.rdy = 1'b0;
        @(negedge clk);
        chk("t2_count3", count, 3);
        chk("t2_head", deq_if.instr, 32'h101);
        tick();

        // 3: sustained enq+deq at count 2, pointers wrap
        do_reset();
        for (int i = 0; i < 2; i++) begin
            drive_enq(1'b1, 32'h300 + i, 32'h30 + i);
            tick();
        end
        for (int i = 0; i < 10; i++) begin
            drive_enq(1'b1, 32'h302 + i, 32'h32 + i);
            deq_if.rdy = 1'b1;
            retire     = (i > 0);
            @(negedge clk);
            chk("t3_count", count, 2);
            tick();
        end
        enq_if.vld = 1'b0;
        deq_if.rdy = 1'b0;
        retire     = 1'b1;
        @(negedge clk);
        chk("t3_head_instr", deq_if.instr, 32'h30A);
        chk("t3_head_xreg", deq_if.xreg, 32'h3A);
        tick();
        retire = 1'b0;

        // 4: in-flight cap
        do_reset();
        deq_if.rdy = 1'b1;
        sent = 0;
        cyc  = 0;
        while (sent < 8 && cyc < 40) begin
            drive_enq(1'b1, 32'h400 + sent, 32'h40 + sent);
            acc = enq_if.rdy;
            tick();
            if (acc) sent++;
            cyc++;
        end
        if (sent < 8) begin
            bad++;
            $display("FAIL t4_enq_timeout: sent %0d expected 8", sent);
        end
        enq_if.vld = 1'b0;
        tick();
        tick();
        tick();
        @(negedge clk);
        chk("t4_capped_vld", deq_if.vld, 0);
        chk("t4_count1", count, 1);
        chk("t4_head", deq_if.instr, 32'h407);
        tick();
        retire = 1'b1;
        tick();
        retire = 1'b0;
        @(negedge clk);
        chk("t4_release_vld", deq_if.vld, 1);
        tick();
        @(negedge clk);
        chk("t4_drained", count, 0);
        tick();

        // 5: flush with concurrent enq and deq
        do_reset();
        drive_enq(1'b1, 32'h500, 32'h50);
        tick();
        enq_if.vld = 1'b0;
        deq_if.rdy = 1'b1;
        tick();
        deq_if.rdy = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive_enq(1'b1, 32'h501 + i, 32'h51 + i);
            tick();
        end
        drive_enq(1'b1, 32'h5FF, 32'h5F);
        deq_if.rdy = 1'b1;
        flush      = 1'b1;
        @(negedge clk);
        chk("t5_pre_count", count, 3);
        tick();
        flush      = 1'b0;
        enq_if.vld = 1'b0;
        deq_if.rdy = 1'b0;
        @(negedge clk);
        chk("t5_count0", count, 0);
        chk("t5_empty", empty, 1);
        chk("t5_not_idle", idle, 0);
        tick();
        retire = 1'b1;
        tick();
        retire = 1'b0;
        @(negedge clk);
        chk("t5_idle", idle, 1);
        chk("t5_no_err", err, 0);
        tick();

        // 6: spurious retire sets sticky err; reset mid-burst
        retire = 1'b1;
        tick();
        retire = 1'b0;
        @(negedge clk);
        chk("t6_err_set", err, 1);
        tick();
        deq_if.rdy = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive_enq(1'b1, 32'h600 + i, 32'h60 + i);
            tick();
        end
        @(negedge clk);
        chk("t6_err_sticky", err, 1);
        tick();
        rst    = 1'b1;
        retire = 1'b1;
        tick();
        rst        = 1'b0;
        retire     = 1'b0;
        enq_if.vld = 1'b0;
        deq_if.rdy = 1'b0;
        @(negedge clk);
        chk("t6_rst_count", count, 0);
        chk("t6_rst_err", err, 0);
        chk("t6_rst_idle", idle, 1);
        chk("t6_rst_deq_vld", deq_if.vld, 0);
        chk("t6_rst_enq_rdy", enq_if.rdy, 1);
        tick();
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not reach the end");
        $display("test done: total=%0d bad=%0d", total, bad + 1);
        $fatal(1, "watchdog expired");
    end
endmodule
